muldiv_seq: RTL
===============

// Module: muldiv_seq
// PURPOSE
//   Iterative unsigned multiply/divide unit for the RISC-V core (MUL, MULHU, DIVU, REMU).
//   Sequences one shared XLEN-bit add/sub step per cycle: shift-add for multiply,
//   restoring shift-subtract for divide. Sits beside the ALU in execute; the control
//   unit raises start and stalls the PC/register write while busy=1, then commits on done.
// PARAMETERS
//   XLEN   32  operand/result width in bits (>= 4)
//   CNTW   6   iteration counter width; must satisfy 2**CNTW > XLEN
// PORTS
//   clk      in   1     clock, all state updates on rising edge
//   reset    in   1     synchronous, active-high
//   start    in   1     request pulse; accepted only when busy=0
//   op       in   2     00 MUL (low word), 01 MULHU (high word), 10 DIVU, 11 REMU
//   a        in   XLEN  multiplicand / dividend, sampled when start is accepted
//   b        in   XLEN  multiplier / divisor, sampled when start is accepted
//   busy     out  1     1 in RUN and DONE states
//   done     out  1     one-cycle pulse: result valid this cycle
//   result   out  XLEN  final value; held stable from done until next accepted start
// BEHAVIOUR
//   Reset: state=IDLE, busy=0, done=0, result=0, counter=0; reset wins over start;
//     asserted mid-operation it aborts the operation, no done pulse is produced.
//   States: IDLE -> RUN on start; RUN -> DONE when counter reaches XLEN;
//     IDLE -> DONE directly on start with op=DIVU/REMU and b==0; DONE -> IDLE always.
//   start while busy=1 is ignored (no re-sample, no restart); op/a/b may change freely
//     after acceptance.
//   Multiply (RUN): acc{hi,lo} is 2*XLEN bits, lo=a, hi=0 at accept. Each cycle:
//     if lo[0], hi += b as an XLEN+1-bit sum (carry kept); then {carry,hi,lo} >>= 1.
//     After XLEN steps: MUL -> lo, MULHU -> hi. Exact unsigned 2*XLEN-bit product.
//   Divide (RUN): rem=0, quo=a at accept. Each cycle: {rem,quo} <<= 1;
//     t = rem - b computed XLEN+1 bits wide; if t nonnegative, rem=t, quo[0]=1.
//     After XLEN steps: DIVU -> quo, REMU -> rem.
//   Divide by zero (b==0): no iteration; DIVU -> all ones, REMU -> a (RISC-V rule).
//   Latency: accept at edge N; done=1 in cycle N+XLEN+1 (33 cycles for XLEN=32);
//     divide-by-zero done=1 in cycle N+1. Throughput: next start accepted the cycle
//     after done (IDLE), i.e. XLEN+2 cycles minimum between accepts.
//   Counter counts 0..XLEN in RUN only, cleared on accept; no wrap occurs.
//   result register written only on the RUN->DONE or IDLE->DONE transition.
//   busy is registered (no combinational path start->busy); done is high exactly
//     one cycle per accepted operation.
// TESTING
//   1. MUL a=7, b=6 -> done after 33 cycles, result=42; MULHU same operands -> 0.
//   2. MULHU a=32'hFFFF_FFFF, b=32'hFFFF_FFFF -> result=32'hFFFF_FFFE; MUL -> 32'h0000_0001.
//   3. DIVU a=100, b=7 -> 14; REMU a=100, b=7 -> 2; DIVU a=5, b=9 -> 0, REMU -> 5.
//   4. DIVU a=123, b=0 -> done one cycle after accept, result=32'hFFFF_FFFF;
//      REMU a=123, b=0 -> 123.
//   5. start held high continuously with changing a/b during RUN -> only first operands
//      used; one done per XLEN+2 cycles; result stable between done pulses.
//   6. reset asserted at cycle 10 of a DIVU -> next cycle busy=0, done=0, result=0;
//      no done pulse; new MUL 3*5 afterwards -> 15.

Source files
------------

// File: rtl/muldiv_seq.sv
// Iterative unsigned multiply/divide unit (MUL, MULHU, DIVU, REMU).
// One shared XLEN+2-bit adder performs a single shift-add (multiply) or
// restoring shift-subtract (divide) step per cycle. The control unit
// stalls while busy_o is high and commits the result on done_o.
module muldiv_seq #(
   parameter int XLEN = 32,
   parameter int CNTW = 6
) (
   input  logic            clk_i,
   input  logic            reset_i,
   input  logic            start_i,
   input  logic [1:0]      op_i,
   input  logic [XLEN-1:0] a_i,
   input  logic [XLEN-1:0] b_i,
   output logic            busy_o,
   output logic            done_o,
   output logic [XLEN-1:0] result_o
);

   typedef enum logic [1:0] {
      S_IDLE = 2'b00,
      S_RUN  = 2'b01,
      S_DONE = 2'b10
   } state_t;

   localparam logic [CNTW-1:0] CNT_LAST = CNTW'(XLEN - 1);

   state_t          state_q, state_d;
   logic [CNTW-1:0] cnt_q, cnt_d;
   logic [XLEN-1:0] result_q, result_d;

   // hi/lo hold the multiply accumulator halves, or remainder/quotient when dividing
   logic [XLEN-1:0] hi_q, hi_d;
   logic [XLEN-1:0] lo_q, lo_d;
   logic [XLEN-1:0] b_q, b_d;
   logic [1:0]      op_q, op_d;

   logic            is_div;
   logic [XLEN:0]   rem_shl;
   logic [XLEN+1:0] add_a, add_b, sum;
   logic            add_cin;
   logic            div_ge;
   logic [XLEN-1:0] step_hi, step_lo;

   // RISC-V divide-by-zero result: quotient is all ones, remainder is the dividend
   function automatic logic [XLEN-1:0] div0_result(input logic rem_op,
                                                   input logic [XLEN-1:0] dividend);
      if (rem_op) begin
         return dividend;
      end
      return '1;
   endfunction

   assign is_div  = op_q[1];
   // remainder shifted left with the next dividend bit; one bit wider than XLEN
   assign rem_shl = {hi_q, lo_q[XLEN-1]};

   // Shared adder operands: hi + (lo[0] ? b : 0) for multiply, rem_shl - b for divide
   always_comb begin
      add_a   = '0;
      add_b   = '0;
      add_cin = 1'b0;
      if (is_div) begin
         add_a   = {1'b0, rem_shl};
         add_b   = ~{2'b00, b_q};
         add_cin = 1'b1;
      end else begin
         add_a = {2'b00, hi_q};
         add_b = lo_q[0] ? {2'b00, b_q} : '0;
      end
   end

   assign sum    = add_a + add_b + {{(XLEN + 1){1'b0}}, add_cin};
   // sign bit clear means the shifted remainder was at least the divisor
   assign div_ge = ~sum[XLEN+1];

   // One iteration of the selected algorithm
   always_comb begin
      step_hi = hi_q;
      step_lo = lo_q;
      if (is_div) begin
         step_hi = div_ge ? sum[XLEN-1:0] : rem_shl[XLEN-1:0];
         step_lo = {lo_q[XLEN-2:0], div_ge};
      end else begin
         // {carry, hi, lo} shifted right by one
         step_hi = sum[XLEN:1];
         step_lo = {sum[0], lo_q[XLEN-1:1]};
      end
   end

   // Next-state logic: accept, iterate, finish
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      result_d = result_q;
      hi_d     = hi_q;
      lo_d     = lo_q;
      b_d      = b_q;
      op_d     = op_q;
      case (state_q)
         S_IDLE: begin
            if (start_i) begin
               op_d  = op_i;
               b_d   = b_i;
               cnt_d = '0;
               if (op_i[1] && (b_i == '0)) begin
                  state_d  = S_DONE;
                  result_d = div0_result(op_i[0], a_i);
               end else begin
                  state_d = S_RUN;
                  hi_d    = '0;
                  lo_d    = a_i;
               end
            end
         end
         S_RUN: begin
            hi_d  = step_hi;
            lo_d  = step_lo;
            cnt_d = cnt_q + CNTW'(1);
            if (cnt_q == CNT_LAST) begin
               state_d  = S_DONE;
               // MULHU and REMU take the upper register, MUL and DIVU the lower
               result_d = op_q[0] ? step_hi : step_lo;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // Control state and result register, cleared by synchronous reset
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q  <= S_IDLE;
         cnt_q    <= '0;
         result_q <= '0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         result_q <= result_d;
      end
   end

   // Datapath registers; only meaningful while RUN, so no reset needed
   always_ff @(posedge clk_i) begin
      hi_q <= hi_d;
      lo_q <= lo_d;
      b_q  <= b_d;
      op_q <= op_d;
   end

   assign busy_o   = (state_q != S_IDLE);
   assign done_o   = (state_q == S_DONE);
   assign result_o = result_q;

endmodule
